// File: rtl/byte_strip_pkg.sv
// Shared constants and types for the byte striper and its lane unstriper.
// Lane order is byte n -> lane n mod LANE_COUNT on both sides of the link.
package byte_strip_pkg;

   localparam int           LANE_COUNT = 4;
   localparam int           BYTE_W     = 8;
   localparam logic [7:0]   IDLE_CHAR  = 8'hBC;  // K28.5
   localparam logic         IDLE_K     = 1'b1;

   typedef logic [1:0] lane_idx_t;

   // A lane carries real data when it lies below the fill position of the group.
   function automatic logic lane_filled(input int lane, input int fill);
      return lane < fill;
   endfunction

endpackage

// File: rtl/byte_strip.sv
// Transmit-side byte striper: groups 4 accepted bytes and publishes them in parallel,
// with FLUSH closing a partial group by padding the unused lanes with an idle character.
module byte_strip #(
   parameter int                                DATA_W    = byte_strip_pkg::BYTE_W,
   parameter logic [DATA_W-1:0]                 IDLE_CHAR = DATA_W'(byte_strip_pkg::IDLE_CHAR),
   parameter logic                              IDLE_K    = byte_strip_pkg::IDLE_K
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] D,
   input  logic              DK,
   input  logic              VALID_IN,
   input  logic              FLUSH,
   output logic [DATA_W-1:0] LANE0,
   output logic [DATA_W-1:0] LANE1,
   output logic [DATA_W-1:0] LANE2,
   output logic [DATA_W-1:0] LANE3,
   output logic              DK_0,
   output logic              DK_1,
   output logic              DK_2,
   output logic              DK_3,
   output logic              LANE_VALID,
   output logic [1:0]        LANE_PTR,
   output logic              PADDED
);
   import byte_strip_pkg::*;

   lane_idx_t         ptr_q;
   logic [DATA_W-1:0] s_d [0:2];
   logic [2:0]        s_k;

   logic [DATA_W-1:0] out_d [0:3];
   logic [3:0]        out_k;
   logic              valid_q;
   logic              padded_q;

   logic [DATA_W-1:0] stage_view [0:3];
   logic [3:0]        stage_k_view;
   logic [2:0]        fill;
   logic              publish;
   logic              pad;
   logic [DATA_W-1:0] nxt_d [0:3];
   logic [3:0]        nxt_k;

   // Lane 3 is never staged: the 4th byte goes straight from D into the output bank.
   always_comb begin
      stage_view[0] = s_d[0];
      stage_view[1] = s_d[1];
      stage_view[2] = s_d[2];
      stage_view[3] = '0;
      stage_k_view  = {1'b0, s_k};
   end

   // fill counts the bytes belonging to the group after this cycle's input (0..4).
   always_comb begin
      fill    = {1'b0, ptr_q} + {2'b00, VALID_IN};
      publish = (VALID_IN && (ptr_q == 2'd3)) || (FLUSH && (fill != 3'd0));
      pad     = publish && (fill != 3'd4);
      nxt_k   = '0;
      for (int i = 0; i < LANE_COUNT; i++) begin
         nxt_d[i] = IDLE_CHAR;
         nxt_k[i] = IDLE_K;
         if (lane_filled(i, int'(ptr_q))) begin
            nxt_d[i] = stage_view[i];
            nxt_k[i] = stage_k_view[i];
         end else if (VALID_IN && (i == int'(ptr_q))) begin
            nxt_d[i] = D;
            nxt_k[i] = DK;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr_q    <= '0;
         s_d[0]   <= '0;
         s_d[1]   <= '0;
         s_d[2]   <= '0;
         s_k      <= '0;
         out_d[0] <= '0;
         out_d[1] <= '0;
         out_d[2] <= '0;
         out_d[3] <= '0;
         out_k    <= '0;
         valid_q  <= 1'b0;
         padded_q <= 1'b0;
      end else begin
         valid_q  <= publish;
         padded_q <= pad;
         if (publish) begin
            out_d[0] <= nxt_d[0];
            out_d[1] <= nxt_d[1];
            out_d[2] <= nxt_d[2];
            out_d[3] <= nxt_d[3];
            out_k    <= nxt_k;
            ptr_q    <= '0;
         end else if (VALID_IN) begin
            s_d[ptr_q] <= D;
            s_k[ptr_q] <= DK;
            ptr_q      <= ptr_q + 2'd1;
         end
      end
   end

   assign LANE0      = out_d[0];
   assign LANE1      = out_d[1];
   assign LANE2      = out_d[2];
   assign LANE3      = out_d[3];
   assign DK_0       = out_k[0];
   assign DK_1       = out_k[1];
   assign DK_2       = out_k[2];
   assign DK_3       = out_k[3];
   assign LANE_VALID = valid_q;
   assign PADDED     = padded_q;
   assign LANE_PTR   = ptr_q;

endmodule

// File: tb/tb_byte_strip.sv
// Randomized and directed bench for byte_strip: a queue-based model groups the byte stream
// and a monitor checks each published group, its latency, held outputs and LANE_PTR.
module tb_byte_strip;
   localparam int W = 37;  // {lane3..lane0, k3..k0, padded}

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] D = '0;
   logic       DK = 1'b0;
   logic       VALID_IN = 1'b0;
   logic       FLUSH = 1'b0;
   logic [7:0] LANE0, LANE1, LANE2, LANE3;
   logic       DK_0, DK_1, DK_2, DK_3;
   logic       LANE_VALID;
   logic [1:0] LANE_PTR;
   logic       PADDED;

   byte_strip dut (
      .CLK(CLK), .RESET(RESET), .D(D), .DK(DK), .VALID_IN(VALID_IN), .FLUSH(FLUSH),
      .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3),
      .DK_0(DK_0), .DK_1(DK_1), .DK_2(DK_2), .DK_3(DK_3),
      .LANE_VALID(LANE_VALID), .LANE_PTR(LANE_PTR), .PADDED(PADDED)
   );

   // ---------------- clock / cycle count ----------------
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           due_q[$];
   logic [8:0]   pend[$];        // {k, d} of bytes in the open group
   logic [W-1:0] last_exp = '0;  // what the held outputs must show
   int           exp_ptr = 0;
   bit           mon_en = 0;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
   endtask

   // Reference model: collect bytes; 4 bytes or a flush with data close a group.
   task automatic model_in(input logic v, input logic f, input logic [7:0] dd, input logic kk);
      logic [W-1:0] g;
      if (v) pend.push_back({kk, dd});
      if (pend.size() == 4 || (f && pend.size() > 0)) begin
         g = '0;
         for (int i = 0; i < 4; i++) begin
            if (i < pend.size()) begin
               g[5 + 8*i +: 8] = pend[i][7:0];
               g[1 + i]        = pend[i][8];
            end else begin
               g[5 + 8*i +: 8] = 8'hBC;
               g[1 + i]        = 1'b1;
            end
         end
         g[0] = (pend.size() < 4);
         exp_q.push_back(g);
         due_q.push_back(cyc + 1);
         pend.delete();
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic f, input logic r,
                       input logic [7:0] dd, input logic kk);
      VALID_IN = v; FLUSH = f; RESET = r; D = dd; DK = kk;
      if (r) pend.delete();
      else model_in(v, f, dd, kk);
      @(posedge CLK); #1;
      if (r) last_exp = '0;
      exp_ptr = pend.size();
      VALID_IN = 1'b0; FLUSH = 1'b0; RESET = 1'b0;
      D = 8'($urandom); DK = 1'($urandom);
   endtask

   task automatic send(input logic [7:0] dd, input logic kk);
      step(1'b1, 1'b0, 1'b0, dd, kk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      logic [W-1:0] e;
      int           due;
      if (mon_en) begin
         if (LANE_VALID) begin
            if (exp_q.size() == 0) begin
               chk("spurious_strobe", 64'(LANE_VALID), 64'd0);
            end else begin
               e   = exp_q.pop_front();
               due = due_q.pop_front();
               chk("lanes", 64'({LANE3, LANE2, LANE1, LANE0}), 64'(e[36:5]));
               chk("dk", 64'({DK_3, DK_2, DK_1, DK_0}), 64'(e[4:1]));
               chk("padded", 64'(PADDED), 64'(e[0]));
               chk("latency", 64'(cyc), 64'(due));
               last_exp = e;
            end
         end else begin
            chk("hold_lanes", 64'({LANE3, LANE2, LANE1, LANE0}), 64'(last_exp[36:5]));
            chk("hold_dk", 64'({DK_3, DK_2, DK_1, DK_0}), 64'(last_exp[4:1]));
            chk("padded_idle", 64'(PADDED), 64'd0);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
               chk("missing_strobe", 64'(LANE_VALID), 64'd1);
               void'(exp_q.pop_front());
               void'(due_q.pop_front());
            end
         end
         chk("lane_ptr", 64'(LANE_PTR), 64'(exp_ptr));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      mon_en = 1;
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      idle(2);

      // single group
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      idle(3);

      // back-to-back groups, K on the first byte of the second group
      for (int i = 1; i <= 8; i++) send(8'(i), (i == 5));
      idle(3);

      // flush of a 2-byte group without data
      send(8'hA1, 0); send(8'hA2, 0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // flush together with the 4th byte, then an empty flush
      send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0);
      step(1'b1, 1'b1, 1'b0, 8'hB4, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // flush with data on lane 0 only, then reset discarding a partial group
      step(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1);
      idle(1);
      send(8'hC1, 0); send(8'hC2, 0);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      idle(1);
      send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
      idle(3);

      // random traffic with gaps, flushes and rare resets
      for (int i = 0; i < 600; i++) begin
         logic v, f, r;
         v = ($urandom_range(0, 99) < 60);
         f = ($urandom_range(0, 99) < 8);
         r = ($urandom_range(0, 299) == 0);
         step(v, f, r, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      end
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
      idle(2);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      mon_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
